gate_seq_ctrl: RTL and testbench
================================

// Module: gate_seq_ctrl
// PURPOSE
//  - Self-checking sequencer for a combinational N-input logic gate (default: 2-input NAND).
//  - On start: drives every input vector 0..2^N_IN-1 onto the gate, waits a settle time, then samples the output.
//  - Compares each sample with the expected truth table, counts mismatches and records the first failing vector.
//  - Sits between a test/control host (start/done handshake) and the gate under control.
// PARAMETERS
//  N_IN    2         gate input count, 1..8
//  TRUTH   4'b0111   expected output table, 2^N_IN bits; bit k = expected y for input vector k (default = NAND)
//  SETTLE  1         cycles between driving a vector and sampling y, 1..255
// PORTS
//  clk       in   1        rising-edge clock
//  rst       in   1        asynchronous reset, active-high
//  start     in   1        level, sampled only in IDLE; begins a run
//  stim      out  N_IN     input vector driven to the gate, MSB = first gate input
//  dut_y     in   1        gate output
//  busy      out  1        high from the cycle after start is accepted until DONE is left
//  done      out  1        one-cycle pulse at end of run
//  pass      out  1        1 = last run had zero mismatches; held until next accepted start
//  err_cnt   out  N_IN+1   mismatch count of current/last run
//  fail_vec  out  N_IN     first failing vector; meaningful only when err_cnt != 0
// BEHAVIOUR
//  - Reset (async, immediate): state=IDLE, stim=0, busy=0, done=0, pass=0, err_cnt=0, fail_vec=0, vec=0, wait counter=0.
//  - FSM states: IDLE, SETTLE, CHECK, DONE.
//  - IDLE: busy=0. If start=1: vec<=0, stim<=0, err_cnt<=0, fail_vec<=0, pass<=0, wait<=SETTLE-1; go to SETTLE.
//  - SETTLE: busy=1, stim held.
//    - wait==0: go to CHECK.
//    - else: wait<=wait-1.
//    - The state lasts exactly SETTLE cycles.
//  - CHECK: busy=1. Compares registered-stable dut_y with TRUTH[vec].
//    - Mismatch: err_cnt<=err_cnt+1. If err_cnt==0, fail_vec<=vec.
//    - vec==2^N_IN-1: go to DONE.
//    - else: vec<=vec+1, stim<=vec+1, wait<=SETTLE-1; go to SETTLE.
//  - DONE: done=1 for one cycle, busy=1, pass<=(final err_cnt==0); go to IDLE.
//    - The mismatch result of the last CHECK is included in pass.
//  - Latency: start sampled in IDLE (edge 0) -> done high in cycle 2^N_IN*(SETTLE+1)+1.
//    - Defaults give done in cycle 9.
//  - err_cnt cannot overflow: the maximum is 2^N_IN, which fits in N_IN+1 bits.
//  - start while busy is ignored and has no effect on the run. start held high across DONE
//    re-triggers a new run on the first IDLE cycle.
//  - stim stays at the last vector after a run until the next start or reset.
//  - Reset mid-run: the run is aborted, all outputs return to reset values, and no done pulse is emitted.
//  - dut_y is sampled only in CHECK. Glitches in SETTLE are irrelevant.
// CONFIGURATION
//  - GATE_SEQ_STOP_ON_FAIL_EN defined:
//    - In CHECK, a mismatch goes directly to DONE regardless of vec.
//    - err_cnt is then 1, fail_vec = failing vector, and pass=0.
//  - GATE_SEQ_STOP_ON_FAIL_EN undefined:
//    - All 2^N_IN vectors are always applied and err_cnt is the full mismatch count.
// TESTING
//  1. Defaults, ideal NAND model. Pulse start for 1 cycle.
//     -> stim steps 0,1,2,3 with each held 2 cycles; done in cycle 9; pass=1, err_cnt=0.
//  2. Gate replaced by AND model.
//     -> err_cnt=4, fail_vec=2'b00, pass=0, done in cycle 9.
//  3. NAND output stuck-at-1.
//     -> err_cnt=1, fail_vec=2'b11, pass=0.
//  4. start re-pulsed in cycles 3 and 6 of a run.
//     -> ignored; a single done in cycle 9 and err_cnt unchanged. SETTLE=3 -> done in cycle 17.
//  5. Assert rst in cycle 5 of a run.
//     -> busy=0, stim=0, err_cnt=0, pass=0 immediately; no done. A new start runs cleanly, as in 1.
//  6. GATE_SEQ_STOP_ON_FAIL_EN defined, AND model.
//     -> done in cycle 3, err_cnt=1, fail_vec=0, stim never leaves 0.

Source files
------------

// File: rtl/gate_seq_ctrl.sv
// Walks every input vector of an N_IN-input gate, checks dut_y against TRUTH, counts mismatches, keeps first failing vector.
// Optional GATE_SEQ_STOP_ON_FAIL_EN: end the run at the first mismatch. Run length 2^N_IN*(SETTLE+1)+1 cycles, start ignored while busy.
module gate_seq_ctrl #(
    parameter int                     N_IN   = 2,
    parameter logic [(1<<N_IN)-1:0]   TRUTH  = 4'b0111,
    parameter int                     SETTLE = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic [N_IN-1:0]   stim,
    input  logic              dut_y,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [N_IN:0]     err_cnt,
    output logic [N_IN-1:0]   fail_vec
);

    localparam int              NVEC      = 1 << N_IN;
    localparam logic [N_IN-1:0] LAST_VEC  = N_IN'(NVEC - 1);
    localparam logic [7:0]      WAIT_INIT = 8'(SETTLE - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETTLE,
        S_CHECK,
        S_DONE
    } state_t;

    state_t          state;
    logic [N_IN-1:0] vec;
    logic [7:0]      wait_cnt;
    logic            mismatch;
    logic            finish_run;

    // stim is only changed at vector boundaries, so dut_y is stable by the CHECK cycle
    assign mismatch = (dut_y != TRUTH[vec]);

`ifdef GATE_SEQ_STOP_ON_FAIL_EN
    assign finish_run = mismatch || (vec == LAST_VEC);
`else
    assign finish_run = (vec == LAST_VEC);
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_IDLE;
            vec      <= '0;
            wait_cnt <= '0;
            stim     <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            pass     <= 1'b0;
            err_cnt  <= '0;
            fail_vec <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        vec      <= '0;
                        stim     <= '0;
                        err_cnt  <= '0;
                        fail_vec <= '0;
                        pass     <= 1'b0;
                        wait_cnt <= WAIT_INIT;
                        busy     <= 1'b1;
                        state    <= S_SETTLE;
                    end
                end
                S_SETTLE: begin
                    if (wait_cnt == 8'd0) begin
                        state <= S_CHECK;
                    end else begin
                        wait_cnt <= wait_cnt - 1'b1;
                    end
                end
                S_CHECK: begin
                    if (mismatch) begin
                        err_cnt <= err_cnt + 1'b1;
                        if (err_cnt == '0) begin
                            fail_vec <= vec;
                        end
                    end
                    if (finish_run) begin
                        done  <= 1'b1;
                        state <= S_DONE;
                    end else begin
                        vec      <= vec + 1'b1;
                        stim     <= vec + 1'b1;
                        wait_cnt <= WAIT_INIT;
                        state    <= S_SETTLE;
                    end
                end
                S_DONE: begin
                    // err_cnt already includes the last CHECK here
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    pass  <= (err_cnt == '0);
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gate_seq_ctrl.sv
// Bench for gate_seq_ctrl: gate models in the bench, table-driven runs with a scoreboard, plus retrigger/reset/SETTLE=3 sequences.
module tb_gate_seq_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start_a = 1'b0;
    logic       start_b = 1'b0;
    logic [1:0] stim_a, stim_b;
    logic       dut_y_a, dut_y_b;
    logic       busy_a, done_a, pass_a, busy_b, done_b, pass_b;
    logic [2:0] err_a, err_b;
    logic [1:0] fail_a, fail_b;
    int         mode_a = 0;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    gate_seq_ctrl #(.N_IN(2), .TRUTH(4'b0111), .SETTLE(1)) dut_a (
        .clk(clk), .rst(rst), .start(start_a), .stim(stim_a), .dut_y(dut_y_a),
        .busy(busy_a), .done(done_a), .pass(pass_a), .err_cnt(err_a), .fail_vec(fail_a)
    );

    gate_seq_ctrl #(.N_IN(2), .TRUTH(4'b0111), .SETTLE(3)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .stim(stim_b), .dut_y(dut_y_b),
        .busy(busy_b), .done(done_b), .pass(pass_b), .err_cnt(err_b), .fail_vec(fail_b)
    );

    // gate models: 0 NAND, 1 AND, 2 stuck-1, 3 stuck-0, 4 XOR, 5 NOR
    always_comb begin
        dut_y_a = 1'b0;
        case (mode_a)
            0: dut_y_a = ~(stim_a[1] & stim_a[0]);
            1: dut_y_a = stim_a[1] & stim_a[0];
            2: dut_y_a = 1'b1;
            3: dut_y_a = 1'b0;
            4: dut_y_a = stim_a[1] ^ stim_a[0];
            5: dut_y_a = ~(stim_a[1] | stim_a[0]);
            default: dut_y_a = 1'b0;
        endcase
    end
    assign dut_y_b = ~(stim_b[1] & stim_b[0]);

    typedef struct {
        int mode;
        int err;
        int fail;
        int pass;
        int done_cyc;
        int last_vec;
    } vec_t;

    vec_t tbl[6];
    vec_t sb[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic score_done(input int cyc);
        vec_t e;
        if (sb.size() == 0) begin
            chk("sb_empty", 1, 0);
        end else begin
            e = sb.pop_front();
            chk("err_cnt", err_a, e.err);
            chk("fail_vec", fail_a, e.fail);
            chk("done_cycle", cyc, e.done_cyc);
        end
    endtask

    task automatic run_a(input int row, input bit repulse, input bit hold);
        vec_t e;
        int   cyc;
        int   exp_stim;
        bit   stim_bad;
        bit   busy_bad;
        e = tbl[row];
        mode_a = e.mode;
        sb.push_back(e);
        @(negedge clk);
        start_a = 1'b1;
        @(posedge clk); #1;
        cyc = 1;
        if (!hold) start_a = 1'b0;
        stim_bad = 1'b0;
        busy_bad = 1'b0;
        while (done_a !== 1'b1 && cyc < 200) begin
            exp_stim = (cyc - 1) / 2;
            if (exp_stim > e.last_vec) exp_stim = e.last_vec;
            if (stim_a !== 2'(exp_stim)) stim_bad = 1'b1;
            if (busy_a !== 1'b1) busy_bad = 1'b1;
            if (repulse) start_a = (cyc == 3 || cyc == 6);
            @(posedge clk); #1;
            cyc++;
        end
        if (repulse) start_a = 1'b0;
        chk("done_seen", done_a, 1'b1);
        chk("stim_seq", stim_bad, 1'b0);
        chk("busy_run", busy_bad, 1'b0);
        chk("busy_in_done", busy_a, 1'b1);
        score_done(cyc);
        @(posedge clk); #1;
        chk("done_pulse_1cyc", done_a, 1'b0);
        chk("pass", pass_a, 32'(e.pass));
        chk("busy_after", busy_a, 1'b0);
        chk("stim_hold", stim_a, 32'(e.last_vec));
    endtask

    initial begin
        int  cyc;
        bit  seen;
        int  ndone;

        tbl[0] = '{0, 0, 0, 1, 9, 3};
        tbl[2] = '{2, 1, 3, 0, 9, 3};
`ifdef GATE_SEQ_STOP_ON_FAIL_EN
        tbl[1] = '{1, 1, 0, 0, 3, 0};
        tbl[3] = '{3, 1, 0, 0, 3, 0};
        tbl[4] = '{4, 1, 0, 0, 3, 0};
        tbl[5] = '{5, 1, 1, 0, 5, 1};
`else
        tbl[1] = '{1, 4, 0, 0, 9, 3};
        tbl[3] = '{3, 3, 0, 0, 9, 3};
        tbl[4] = '{4, 1, 0, 0, 9, 3};
        tbl[5] = '{5, 2, 1, 0, 9, 3};
`endif

        repeat (2) @(posedge clk);
        #1;
        chk("rst_stim", stim_a, 0);
        chk("rst_busy", busy_a, 0);
        chk("rst_done", done_a, 0);
        chk("rst_pass", pass_a, 0);
        chk("rst_err", err_a, 0);
        chk("rst_fail", fail_a, 0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 6; i++) begin
            run_a(i, 1'b0, 1'b0);
        end

        // start re-pulsed mid-run must be ignored
        run_a(2, 1'b1, 1'b0);
        @(posedge clk); #1;
        chk("repulse_no_rerun", busy_a, 0);

        // start held across DONE retriggers on the first IDLE cycle
        run_a(0, 1'b0, 1'b1);
        sb.push_back(tbl[0]);
        @(posedge clk); #1;
        chk("retrig_busy", busy_a, 1);
        start_a = 1'b0;
        cyc = 1;
        while (done_a !== 1'b1 && cyc < 200) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk("retrig_done", done_a, 1);
        score_done(cyc);

        // SETTLE=3 with re-pulsed start: single done in cycle 17
        @(negedge clk);
        start_b = 1'b1;
        @(posedge clk); #1;
        start_b = 1'b0;
        cyc = 1;
        while (done_b !== 1'b1 && cyc < 200) begin
            start_b = (cyc == 3 || cyc == 6);
            @(posedge clk); #1;
            cyc++;
        end
        start_b = 1'b0;
        chk("s3_done_cycle", cyc, 17);
        chk("s3_err", err_b, 0);
        ndone = 0;
        repeat (6) begin
            @(posedge clk); #1;
            if (done_b === 1'b1) ndone++;
        end
        chk("s3_single_done", ndone, 0);
        chk("s3_pass", pass_b, 1);

        // reset in cycle 5 of a run aborts it without a done pulse
        mode_a = 0;
        @(negedge clk);
        start_a = 1'b1;
        @(posedge clk); #1;
        start_a = 1'b0;
        repeat (4) begin
            @(posedge clk); #1;
        end
        chk("pre_rst_stim", stim_a, 2);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_busy", busy_a, 0);
        chk("mid_rst_stim", stim_a, 0);
        chk("mid_rst_err", err_a, 0);
        chk("mid_rst_pass", pass_a, 0);
        @(negedge clk);
        rst = 1'b0;
        seen = 1'b0;
        repeat (12) begin
            @(posedge clk); #1;
            if (done_a === 1'b1 || busy_a === 1'b1) seen = 1'b1;
        end
        chk("no_done_after_rst", seen, 0);
        run_a(0, 1'b0, 1'b0);

        chk("sb_drained", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
